// File: rtl/ddr_scrub_ctl_pkg.sv
// Shared definitions for the DDR zero-fill scrubber: FSM encoding, burst geometry
// and AXI write constants.
package ddr_scrub_ctl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AW    = 3'd1,
        ST_W     = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } scrub_state_e;

    localparam int unsigned BURST_BYTES = 4096;
    localparam int unsigned BEATS       = 64;
    localparam int unsigned BEAT_W      = $clog2(BEATS);
    localparam int unsigned DATA_W      = 512;
    localparam int unsigned STRB_W      = DATA_W / 8;

    localparam logic [7:0] AXI_LEN  = 8'(BEATS - 1);
    localparam logic [2:0] AXI_SIZE = 3'd6;

    function automatic logic [63:0] next_burst(input logic [63:0] addr);
        return addr + 64'(BURST_BYTES);
    endfunction

endpackage

// File: rtl/ddr_scrub_ctl_outst.sv
// scrub_outst_cnt: saturating up/down count of AXI write bursts still awaiting a
// B response, with full/empty flags for the AW throttle and the drain exit.
module scrub_outst_cnt #(
    parameter int unsigned MAX_OUTST = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_inc, do_dec;

    always_comb begin
        // A simultaneous inc/dec is always legal, even at the limits.
        do_inc = inc && (!full || dec);
        do_dec = dec && (!empty || inc);
        cnt_d  = cnt_q;
        if (do_inc && !do_dec) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_dec && !do_inc) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full  = (cnt_q == CNT_W'(MAX_OUTST));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/ddr_scrub_ctl.sv
// DDR scrubber: zero-fills [0, ADDR_LIMIT) with 4 KiB AXI write bursts.
// Build option SCRUB_ERR_STOP_EN: a B error aborts the scrub and ends in DONE.
//
// state | meaning
// IDLE  | waiting for scrb_enable
// AW    | presenting the next burst address (held back while outstanding is full)
// W     | streaming the 64 zero beats of the accepted burst
// DRAIN | no new bursts; waiting for all B responses
// DONE  | region finished (or error stop); held until scrb_enable drops
module ddr_scrub_ctl
    import ddr_scrub_ctl_pkg::*;
#(
    parameter logic [63:0] ADDR_LIMIT = 64'h4_0000_0000,
    parameter int unsigned MAX_OUTST  = 8,
    parameter logic [15:0] AXI_ID     = 16'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scrb_enable,
    output logic [63:0]       scrb_addr,
    output logic [2:0]        scrb_state,
    output logic              scrb_done,
    output logic              scrb_err,
    output logic [15:0]       awid,
    output logic [63:0]       awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [15:0]       wid,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [15:0]       bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    scrub_state_e      state_q, state_d;
    logic [63:0]       addr_cnt_q, addr_cnt_d;
    logic [63:0]       scrb_addr_q, scrb_addr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              err_q, err_d;
    logic              outst_full, outst_empty;
    logic              aw_hs, w_hs, b_hs;
    logic              err_stop, abort;
    logic [63:0]       addr_next;

    assign bready = 1'b1;

    // Responses carrying a foreign ID are not ours to count.
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bvalid && bready && (bid == AXI_ID);

    assign addr_next = next_burst(addr_cnt_q);

`ifdef SCRUB_ERR_STOP_EN
    assign err_stop = err_q;
`else
    assign err_stop = 1'b0;
`endif

    assign abort = !scrb_enable || err_stop;

    // Outstanding only grows on an AW handshake, so awvalid cannot fall before awready.
    assign awvalid = (state_q == ST_AW) && !outst_full;
    assign wvalid  = (state_q == ST_W);
    assign wlast   = wvalid && (beat_q == BEAT_W'(BEATS - 1));

    assign awid   = AXI_ID;
    assign awaddr = addr_cnt_q;
    assign awlen  = AXI_LEN;
    assign awsize = AXI_SIZE;
    assign wid    = AXI_ID;
    assign wdata  = '0;
    assign wstrb  = '1;

    assign scrb_addr  = scrb_addr_q;
    assign scrb_state = state_q;
    assign scrb_done  = (state_q == ST_DONE);
    assign scrb_err   = err_q;

    scrub_outst_cnt #(
        .MAX_OUTST (MAX_OUTST)
    ) u_outst (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (aw_hs),
        .dec   (b_hs),
        .full  (outst_full),
        .empty (outst_empty)
    );

    always_comb begin
        state_d     = state_q;
        addr_cnt_d  = addr_cnt_q;
        scrb_addr_d = scrb_addr_q;
        beat_d      = beat_q;
        err_d       = err_q;

        if (b_hs && (bresp != 2'b00)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (scrb_enable) begin
                    state_d     = ST_AW;
                    addr_cnt_d  = '0;
                    scrb_addr_d = '0;
                    beat_d      = '0;
                end
            end
            ST_AW: begin
                if (aw_hs) begin
                    state_d     = ST_W;
                    scrb_addr_d = addr_cnt_q;
                    beat_d      = '0;
                end else if (outst_full && abort) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_W: begin
                if (w_hs) begin
                    if (wlast) begin
                        beat_d     = '0;
                        addr_cnt_d = addr_next;
                        if ((addr_next < ADDR_LIMIT) && !abort) begin
                            state_d = ST_AW;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Reaching the limit means the region is covered, even if enable dropped late.
                if (outst_empty) begin
                    if ((addr_cnt_q >= ADDR_LIMIT) || err_stop) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                if (!scrb_enable) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_cnt_q  <= '0;
            scrb_addr_q <= '0;
            beat_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_cnt_q  <= addr_cnt_d;
            scrb_addr_q <= scrb_addr_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_ddr_scrub_ctl.sv
// Scoreboard bench for ddr_scrub_ctl: 16 KiB region, two outstanding bursts.
module tb_ddr_scrub_ctl;

    localparam logic [63:0] LIMIT = 64'h4000;
    localparam logic [15:0] ID    = 16'h00A5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         scrb_enable = 1'b0;
    logic [63:0]  scrb_addr;
    logic [2:0]   scrb_state;
    logic         scrb_done, scrb_err;
    logic [15:0]  awid, wid;
    logic [63:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic         awvalid, wvalid, wlast, bready;
    logic         awready = 1'b1;
    logic         wready = 1'b1;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic [15:0]  bid = ID;
    logic [1:0]   bresp = 2'b00;
    logic         bvalid = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_aw_q[$];
    int aw_count = 0;
    int beat_total = 0;
    int beat_in_burst = 0;
    int b_owed = 0;
    int b_sent = 0;
    int b_credit = 1000000;
    int err_burst = -1;

    always #5 clk = ~clk;

    ddr_scrub_ctl #(
        .ADDR_LIMIT (LIMIT),
        .MAX_OUTST  (2),
        .AXI_ID     (ID)
    ) dut (
        .clk (clk), .rst_n (rst_n), .scrb_enable (scrb_enable),
        .scrb_addr (scrb_addr), .scrb_state (scrb_state),
        .scrb_done (scrb_done), .scrb_err (scrb_err),
        .awid (awid), .awaddr (awaddr), .awlen (awlen), .awsize (awsize),
        .awvalid (awvalid), .awready (awready),
        .wid (wid), .wdata (wdata), .wstrb (wstrb), .wlast (wlast),
        .wvalid (wvalid), .wready (wready),
        .bid (bid), .bresp (bresp), .bvalid (bvalid), .bready (bready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, input string name);
        int i;
        i = 0;
        while (scrb_state !== s && i < max) begin
            step(1);
            i++;
        end
        if (scrb_state !== s) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: state %0d expected %0d", name, scrb_state, s);
        end
    endtask

    task automatic clear_stats();
        exp_aw_q.delete();
        aw_count   = 0;
        beat_total = 0;
        b_sent     = 0;
    endtask

    task automatic push_region(input int n);
        for (int k = 0; k < n; k++) exp_aw_q.push_back(64'(k) * 64'h1000);
    endtask

    // Monitor: checks every AW/W handshake against the scoreboard, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            beat_in_burst = 0;
        end else begin
            if (awvalid && awready) begin
                if (exp_aw_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL aw_unexpected: got awaddr %0h, expected no AW", awaddr);
                end else begin
                    chk("awaddr", awaddr, exp_aw_q.pop_front());
                end
                chk("awlen", 64'(awlen), 64'd63);
                chk("awsize", 64'(awsize), 64'd6);
                chk("awid", 64'(awid), 64'(ID));
                aw_count++;
            end
            if (wvalid && wready) begin
                chk("wlast", 64'(wlast), 64'(beat_in_burst == 63));
                chk("w_payload", 64'(wdata == '0 && wstrb == '1 && wid == ID), 64'd1);
                beat_total++;
                beat_in_burst = (beat_in_burst == 63) ? 0 : beat_in_burst + 1;
            end
        end
    end

    // B slave: one response owed per completed burst, gated by b_credit.
    initial forever begin
        logic w_last_hs, b_hs;
        @(negedge clk);
        w_last_hs = wvalid && wready && wlast;
        b_hs      = bvalid && bready;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            b_owed = 0;
            bvalid = 1'b0;
        end else begin
            if (w_last_hs) b_owed++;
            if (b_hs) begin
                b_owed--;
                b_sent++;
                if (b_credit > 0) b_credit--;
            end
            bvalid = (b_owed > 0) && (b_credit > 0);
            bresp  = (b_sent == err_burst) ? 2'b10 : 2'b00;
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        step(3);
        chk("rst_state", 64'(scrb_state), 64'd0);
        chk("rst_done", 64'(scrb_done), 64'd0);
        chk("rst_err", 64'(scrb_err), 64'd0);
        chk("rst_addr", scrb_addr, 64'd0);
        chk("rst_awvalid", 64'(awvalid), 64'd0);
        chk("rst_wvalid", 64'(wvalid), 64'd0);
        chk("rst_bready", 64'(bready), 64'd1);
        rst_n = 1'b1;
        step(2);

        // Full region, always-ready slave
        clear_stats();
        push_region(4);
        scrb_enable = 1'b1;
        wait_state(3'd4, 2000, "full_done");
        chk("full_done", 64'(scrb_done), 64'd1);
        chk("full_state", 64'(scrb_state), 64'd4);
        chk("full_beats", 64'(beat_total), 64'd256);
        chk("full_aws", 64'(aw_count), 64'd4);
        chk("full_err", 64'(scrb_err), 64'd0);
        chk("full_addr", scrb_addr, 64'h3000);
        chk("full_q_empty", 64'(exp_aw_q.size()), 64'd0);
        scrb_enable = 1'b0;
        wait_state(3'd0, 20, "full_idle");
        chk("full_done_clr", 64'(scrb_done), 64'd0);

        // Outstanding limit: no B responses until released
        clear_stats();
        b_credit = 0;
        push_region(2);
        scrb_enable = 1'b1;
        step(200);
        chk("stall_aws", 64'(aw_count), 64'd2);
        chk("stall_awvalid", 64'(awvalid), 64'd0);
        chk("stall_state", 64'(scrb_state), 64'd1);
        chk("stall_beats", 64'(beat_total), 64'd128);
        exp_aw_q.push_back(64'h2000);
        exp_aw_q.push_back(64'h3000);
        b_credit = 1;
        n = 0;
        while (aw_count < 3 && n < 20) begin step(1); n++; end
        chk("resume_aws", 64'(aw_count), 64'd3);
        step(150);
        chk("restall_aws", 64'(aw_count), 64'd3);
        b_credit = 1000000;
        wait_state(3'd4, 500, "stall_done");
        chk("stall_total_aws", 64'(aw_count), 64'd4);
        chk("stall_total_beats", 64'(beat_total), 64'd256);
        scrb_enable = 1'b0;
        wait_state(3'd0, 20, "stall_idle");

        // Abort on beat 10 of burst 2
        clear_stats();
        push_region(2);
        scrb_enable = 1'b1;
        n = 0;
        while (!(aw_count == 2 && beat_in_burst == 10) && n < 500) begin step(1); n++; end
        chk("abort_reached", 64'(aw_count == 2 && beat_in_burst == 10), 64'd1);
        scrb_enable = 1'b0;
        wait_state(3'd0, 200, "abort_idle");
        chk("abort_beats", 64'(beat_total), 64'd128);
        chk("abort_aws", 64'(aw_count), 64'd2);
        chk("abort_done", 64'(scrb_done), 64'd0);
        step(20);
        chk("abort_no_restart", 64'(aw_count), 64'd2);
        chk("abort_q_empty", 64'(exp_aw_q.size()), 64'd0);

        // Error response on burst 1
        clear_stats();
        err_burst = 0;
`ifdef SCRUB_ERR_STOP_EN
        push_region(2);
`else
        push_region(4);
`endif
        scrb_enable = 1'b1;
        wait_state(3'd4, 2000, "err_done");
        chk("err_flag", 64'(scrb_err), 64'd1);
        chk("err_done", 64'(scrb_done), 64'd1);
`ifdef SCRUB_ERR_STOP_EN
        chk("err_aws", 64'(aw_count), 64'd2);
        chk("err_beats", 64'(beat_total), 64'd128);
`else
        chk("err_aws", 64'(aw_count), 64'd4);
        chk("err_beats", 64'(beat_total), 64'd256);
`endif
        err_burst = -1;
        scrb_enable = 1'b0;
        wait_state(3'd0, 20, "err_idle");
        chk("err_cleared", 64'(scrb_err), 64'd0);

        // Reset pulse during W, then a fresh run
        clear_stats();
        push_region(4);
        scrb_enable = 1'b1;
        n = 0;
        while (beat_total < 5 && n < 100) begin step(1); n++; end
        chk("rstw_in_w", 64'(scrb_state), 64'd2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rstw_state", 64'(scrb_state), 64'd0);
        chk("rstw_awvalid", 64'(awvalid), 64'd0);
        chk("rstw_wvalid", 64'(wvalid), 64'd0);
        chk("rstw_wlast", 64'(wlast), 64'd0);
        chk("rstw_bready", 64'(bready), 64'd1);
        chk("rstw_done", 64'(scrb_done), 64'd0);
        chk("rstw_err", 64'(scrb_err), 64'd0);
        chk("rstw_addr", scrb_addr, 64'd0);
        scrb_enable = 1'b0;
        step(2);
        clear_stats();
        rst_n = 1'b1;
        step(10);
        chk("rstw_no_partial", 64'(beat_total + aw_count), 64'd0);
        push_region(4);
        scrb_enable = 1'b1;
        wait_state(3'd4, 2000, "rstw_done");
        chk("rstw_aws", 64'(aw_count), 64'd4);
        chk("rstw_beats", 64'(beat_total), 64'd256);
        scrb_enable = 1'b0;
        wait_state(3'd0, 20, "rstw_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
